alu_rr_sequencer: RTL and testbench

- Shares one 3-bit signed ALU between two requesters. Ops: add, sub, and, or.
- Round-robin arbitration; one operation in flight at a time.
- Returns a registered result with a signed-overflow flag on a single response channel.
- Drives the 7-segment code of the last result. Sits between switch/FSM-driven requesters and the board SEG display.

---
 rtl/alu_seq_pkg.sv | 44 ++++
 rtl/alu3.sv | 47 ++++
 rtl/alu_rr_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_rr_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types, 7-segment codes and the 3-bit segment decoder for the ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [7:0] MENOS_QUATRO = 8'hE6;
  localparam logic [7:0] MENOS_TRES   = 8'hCF;
  localparam logic [7:0] MENOS_DOIS   = 8'hDB;
  localparam logic [7:0] MENOS_UM     = 8'h86;
  localparam logic [7:0] ZERO         = 8'h3F;
  localparam logic [7:0] UM           = 8'h06;
  localparam logic [7:0] DOIS         = 8'h5B;
  localparam logic [7:0] TRES         = 8'h4F;
  localparam logic [7:0] OVERFLOW     = 8'h80;

  function automatic logic [7:0] seg_decode(input logic signed [2:0] v);
    logic [2:0] u;
    logic [7:0] code;
    u = v;
    case (u)
      3'b100:  code = MENOS_QUATRO;
      3'b101:  code = MENOS_TRES;
      3'b110:  code = MENOS_DOIS;
      3'b111:  code = MENOS_UM;
      3'b000:  code = ZERO;
      3'b001:  code = UM;
      3'b010:  code = DOIS;
      default: code = TRES;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu3.sv
// Combinational signed ALU (add, sub, and, or) with overflow detection.
// Saturation on add/sub overflow is enabled by defining ALU_SAT_EN.
module alu3
  import alu_seq_pkg::*;
#(
  parameter int unsigned NBITS = 3
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [1:0]       f,
  output logic [NBITS-1:0] y,
  output logic             ovf
);

  logic [NBITS:0] w_a_ext;
  logic [NBITS:0] w_b_ext;
  logic [NBITS:0] w_wide;

  assign w_a_ext = {a[NBITS-1], a};
  assign w_b_ext = {b[NBITS-1], b};

  always_comb begin
    w_wide = '0;
    y      = '0;
    ovf    = 1'b0;
    case (alu_op_t'(f))
      ADD, SUB: begin
        w_wide = (alu_op_t'(f) == ADD) ? (w_a_ext + w_b_ext) : (w_a_ext - w_b_ext);
        // Sign-extended result disagreeing with its truncated sign bit means out of range.
        ovf = w_wide[NBITS] ^ w_wide[NBITS-1];
`ifdef ALU_SAT_EN
        if (ovf) begin
          y = w_wide[NBITS] ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
        end else begin
          y = w_wide[NBITS-1:0];
        end
`else
        y = w_wide[NBITS-1:0];
`endif
      end
      AND:     y = a & b;
      OR:      y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one alu3 between two requesters, with registered response
// and 7-segment output. ALU_SAT_EN selects saturating add/sub (seg then shows the clamp).
module alu_rr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NBITS = 3,
  parameter int unsigned NREQ  = 2
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NBITS-1:0] req0_a,
  input  logic [NBITS-1:0] req0_b,
  input  logic [1:0]       req0_f,
  input  logic [NBITS-1:0] req1_a,
  input  logic [NBITS-1:0] req1_b,
  input  logic [1:0]       req1_f,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [NBITS-1:0] resp_result,
  output logic             resp_ovf,
  output logic [7:0]       seg,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last;
  logic             r_id;
  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [1:0]       r_f;
  logic [NBITS-1:0] r_result;
  logic             r_ovf;
  logic [7:0]       r_seg;

  logic             w_gid;
  logic             w_take;
  logic [NBITS-1:0] w_y;
  logic             w_ovf;
  logic [7:0]       w_seg;

  alu3 #(
    .NBITS(NBITS)
  ) u_alu (
    .a  (r_a),
    .b  (r_b),
    .f  (r_f),
    .y  (w_y),
    .ovf(w_ovf)
  );

  if (NBITS == 3) begin : g_seg
`ifdef ALU_SAT_EN
    assign w_seg = seg_decode(w_y);
`else
    assign w_seg = w_ovf ? OVERFLOW : seg_decode(w_y);
`endif
  end else begin : g_no_seg
    assign w_seg = 8'h00;
  end

  always_comb begin
    w_gid        = req_valid[1];
    w_take       = 1'b0;
    w_state_next = r_state;
    req_ready    = '0;
    // On a tie, serve whoever was not served last.
    if (req_valid[0] && req_valid[1]) begin
      w_gid = ~r_last;
    end
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_take       = 1'b1;
          req_ready    = w_gid ? 2'b10 : 2'b01;
          w_state_next = EXEC;
        end
      end
      EXEC:    w_state_next = RESP;
      RESP:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_f      <= 2'b00;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_seg    <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_last <= w_gid;
        r_id   <= w_gid;
        r_a    <= w_gid ? req1_a : req0_a;
        r_b    <= w_gid ? req1_b : req0_b;
        r_f    <= w_gid ? req1_f : req0_f;
      end
      if (r_state == EXEC) begin
        r_result <= w_y;
        r_ovf    <= w_ovf;
        r_seg    <= w_seg;
      end
    end
  end

  assign resp_valid  = (r_state == RESP);
  assign busy        = (r_state != IDLE);
  assign resp_id     = r_id;
  assign resp_result = r_result;
  assign resp_ovf    = r_ovf;
  assign seg         = r_seg;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench for alu_rr_sequencer: directed plan vectors plus randomized operations
// checked against an integer-arithmetic reference model.
module tb_alu_rr_sequencer;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_f, req1_f;
  logic       resp_valid, resp_ready, resp_id, resp_ovf, busy;
  logic [2:0] resp_result;
  logic [7:0] seg;

  int n_pass  = 0;
  int n_total = 0;
  int tb_last = 1;

  alu_rr_sequencer #(
    .NBITS(3),
    .NREQ (2)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_f     (req0_f),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_f     (req1_f),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_result(resp_result),
    .resp_ovf   (resp_ovf),
    .seg        (seg),
    .busy       (busy)
  );

  always #5 clk_2 = ~clk_2;

  // Reference: exact integer result, range check against [-4,3], table lookup for seg.
  function automatic void model(input logic [2:0] a, input logic [2:0] b, input logic [1:0] f,
                                output logic [2:0] y, output logic ovf, output logic [7:0] sg);
    logic [7:0] tbl [8];
    int sa, sb, t, v;
    tbl = '{8'hE6, 8'hCF, 8'hDB, 8'h86, 8'h3F, 8'h06, 8'h5B, 8'h4F};
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ovf = 1'b0;
    t   = 0;
    if (f == 2'd2) y = a & b;
    else if (f == 2'd3) y = a | b;
    else begin
      t   = (f == 2'd0) ? sa + sb : sa - sb;
      ovf = (t < -4) || (t > 3);
`ifdef ALU_SAT_EN
      if (t > 3) t = 3;
      if (t < -4) t = -4;
`endif
      y = t[2:0];
    end
    v = int'($signed(y));
`ifdef ALU_SAT_EN
    sg = tbl[v + 4];
`else
    sg = ovf ? 8'h80 : tbl[v + 4];
`endif
  endfunction

  // Drives one op from IDLE (entered at posedge+1) with resp_ready high and returns what
  // was observed at grant and in RESP; ends at posedge+1 back in IDLE.
  task automatic do_op(input int who, input logic [2:0] a, input logic [2:0] b,
                       input logic [1:0] f, output logic [1:0] rdy, output logic bsy,
                       output logic vld, output logic id, output logic [2:0] y,
                       output logic ovf, output logic [7:0] sg);
    if (who == 0) begin
      req0_a = a; req0_b = b; req0_f = f; req_valid = 2'b01;
    end else begin
      req1_a = a; req1_b = b; req1_f = f; req_valid = 2'b10;
    end
    resp_ready = 1'b1;
    #1 rdy = req_ready;
    @(posedge clk_2); #1;
    req_valid = 2'b00;
    bsy = busy;
    @(posedge clk_2); #1;
    vld = resp_valid; id = resp_id; y = resp_result; ovf = resp_ovf; sg = seg;
    @(posedge clk_2); #1;
    tb_last = who;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_f = '0; req1_a = '0; req1_b = '0; req1_f = '0;
    repeat (2) @(posedge clk_2);
    #1 reset = 1'b0;
    tb_last = 1;
    #1;
    n_total++;
    if ({req_ready, resp_valid, resp_id, resp_result, resp_ovf, seg, busy} !== 16'h0)
      $display("FAIL reset_outputs: got rdy=%b v=%b id=%b r=%b o=%b seg=%h busy=%b want all 0",
               req_ready, resp_valid, resp_id, resp_result, resp_ovf, seg, busy);
    else n_pass++;
    @(posedge clk_2); #1;
    n_total++;
    if ({busy, req_ready} !== 3'b000)
      $display("FAIL reset_idle: got busy=%b rdy=%b want 0/00", busy, req_ready);
    else n_pass++;
  endtask

  task automatic run_checked(input string nm, input int who, input logic [2:0] a,
                             input logic [2:0] b, input logic [1:0] f);
    logic [1:0] rdy;
    logic bsy, vld, id, ovf, e_ovf;
    logic [2:0] y, e_y;
    logic [7:0] sg, e_sg;
    model(a, b, f, e_y, e_ovf, e_sg);
    do_op(who, a, b, f, rdy, bsy, vld, id, y, ovf, sg);
    n_total++;
    if (rdy !== ((who == 0) ? 2'b01 : 2'b10) || bsy !== 1'b1)
      $display("FAIL %s_grant: got rdy=%b busy=%b want rdy=%b busy=1", nm, rdy, bsy,
               (who == 0) ? 2'b01 : 2'b10);
    else n_pass++;
    n_total++;
    if ({vld, id, y, ovf, sg} !== {1'b1, who[0], e_y, e_ovf, e_sg})
      $display("FAIL %s_resp: got v=%b id=%b r=%b o=%b seg=%h want v=1 id=%0d r=%b o=%b seg=%h",
               nm, vld, id, y, ovf, sg, who, e_y, e_ovf, e_sg);
    else n_pass++;
  endtask

  task automatic test_arith;
    run_checked("add_ovf", 0, 3'b011, 3'b010, 2'b00);
    run_checked("sub_neg", 1, 3'b110, 3'b001, 2'b01);
    run_checked("sub_ovf", 1, 3'b100, 3'b001, 2'b01);
  endtask

  task automatic test_logic;
    run_checked("and", 0, 3'b110, 3'b011, 2'b10);
    run_checked("or", 1, 3'b100, 3'b001, 2'b11);
  endtask

  task automatic test_back_to_back;
    logic [2:0] e_y;
    logic e_ovf;
    logic [7:0] e_sg;
    int g;
    reset = 1'b1;
    @(posedge clk_2); #1;
    reset = 1'b0; tb_last = 1;
    req0_a = 3'($urandom); req0_b = 3'($urandom); req0_f = 2'($urandom);
    req1_a = 3'($urandom); req1_b = 3'($urandom); req1_f = 2'($urandom);
    req_valid = 2'b11; resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = 1 - tb_last;
      if (g == 0) model(req0_a, req0_b, req0_f, e_y, e_ovf, e_sg);
      else model(req1_a, req1_b, req1_f, e_y, e_ovf, e_sg);
      #1;
      n_total++;
      if (req_ready !== ((g == 0) ? 2'b01 : 2'b10))
        $display("FAIL b2b_grant%0d: got rdy=%b want grant to %0d", k, req_ready, g);
      else n_pass++;
      @(posedge clk_2); #1;
      if (g == 0) begin
        req0_a = 3'($urandom); req0_b = 3'($urandom); req0_f = 2'($urandom);
      end else begin
        req1_a = 3'($urandom); req1_b = 3'($urandom); req1_f = 2'($urandom);
      end
      tb_last = g;
      #1;
      n_total++;
      if ({req_ready, resp_valid, busy} !== 4'b0001)
        $display("FAIL b2b_exec%0d: got rdy=%b v=%b busy=%b want 00/0/1", k, req_ready,
                 resp_valid, busy);
      else n_pass++;
      @(posedge clk_2); #1;
      n_total++;
      if ({req_ready, resp_valid, resp_id, resp_result, resp_ovf} !==
          {2'b00, 1'b1, g[0], e_y, e_ovf})
        $display("FAIL b2b_resp%0d: got rdy=%b v=%b id=%b r=%b o=%b want 00/1/%0d/%b/%b", k,
                 req_ready, resp_valid, resp_id, resp_result, resp_ovf, g, e_y, e_ovf);
      else n_pass++;
      @(posedge clk_2);
    end
    #1 req_valid = 2'b00;
    @(posedge clk_2); #1;
  endtask

  task automatic test_stall;
    logic [2:0] e_y;
    logic e_ovf;
    logic [7:0] e_sg;
    model(3'b001, 3'b001, 2'b00, e_y, e_ovf, e_sg);
    req0_a = 3'b001; req0_b = 3'b001; req0_f = 2'b00;
    req_valid = 2'b01; resp_ready = 1'b0;
    @(posedge clk_2); #1;
    req_valid = 2'b00;
    @(posedge clk_2); #1;
    tb_last = 0;
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_total++;
      if ({resp_valid, busy, req_ready, resp_id, resp_result, resp_ovf, seg} !==
          {1'b1, 1'b1, 2'b00, 1'b0, e_y, e_ovf, e_sg})
        $display("FAIL stall%0d: got v=%b busy=%b rdy=%b id=%b r=%b seg=%h want 1/1/00/0/%b/%h",
                 k, resp_valid, busy, req_ready, resp_id, resp_result, seg, e_y, e_sg);
      else n_pass++;
      @(posedge clk_2); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk_2); #1;
    n_total++;
    if ({resp_valid, busy, req_ready, seg} !== {1'b0, 1'b0, 2'b10, e_sg})
      $display("FAIL stall_release: got v=%b busy=%b rdy=%b seg=%h want 0/0/10/%h", resp_valid,
               busy, req_ready, seg, e_sg);
    else n_pass++;
    req_valid = 2'b00;
    @(posedge clk_2); #1;
  endtask

  task automatic test_reset_mid;
    req1_a = 3'b010; req1_b = 3'b001; req1_f = 2'b00;
    req_valid = 2'b10; resp_ready = 1'b1;
    @(posedge clk_2); #1;
    req_valid = 2'b00;
    reset = 1'b1;
    @(posedge clk_2); #1;
    n_total++;
    if ({resp_valid, busy, seg, resp_result, resp_ovf, resp_id, req_ready} !== 16'h0)
      $display("FAIL reset_mid: got v=%b busy=%b seg=%h r=%b o=%b id=%b rdy=%b want all 0",
               resp_valid, busy, seg, resp_result, resp_ovf, resp_id, req_ready);
    else n_pass++;
    reset = 1'b0; tb_last = 1;
    req_valid = 2'b11;
    #1;
    n_total++;
    if (req_ready !== 2'b01)
      $display("FAIL reset_mid_tie: got rdy=%b want 01", req_ready);
    else n_pass++;
    req_valid = 2'b00;
    @(posedge clk_2); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_mid_nogrant: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int k = 0; k < 30; k++) begin
      run_checked($sformatf("rand%0d", k), int'($urandom_range(0, 1)), 3'($urandom),
                  3'($urandom), 2'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
